simple_arb: RTL

SIMPLE_ARB -- requirements
Module: simple_arb

---
 rtl/simple_arb_pkg.sv | 24 ++
 rtl/simple_arb_pick.sv | 54 +++++
 rtl/simple_arb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/simple_arb_pkg.sv
// simple_arb_pkg -- shared types and defaults for the simple_arb arbiter.
//
// Contents:
//   DEF_M_CNT / DEF_AW / DEF_DW  default master count, address width, data width
//   arb_state_e                  arbiter FSM state encoding (IDLE, ISSUE, RESP)
//   idx_width()                  width of an encoded master index (at least 1 bit)
package simple_arb_pkg;

  localparam int DEF_M_CNT = 2;
  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Width needed to hold an encoded master index; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simple_arb_pick.sv
// simple_arb_pick -- combinational winner selection for simple_arb.
//
// The search starts at index ptr+1 (modulo M_CNT) and returns the first
// requesting master. Passing ptr = M_CNT-1 makes the search start at master 0,
// which turns this into a lowest-index-wins fixed priority picker.
//
// Ports:
//   req    in   M_CNT  request vector, one bit per master
//   ptr    in   IW     index of the most recently granted master
//   grant  out  M_CNT  one-hot winner (all zero when nobody requests)
//   idx    out  IW     encoded winner index (0 when nobody requests)
//   any    out  1      at least one request is present
module simple_arb_pick
  import simple_arb_pkg::*;
#(
  parameter int M_CNT = DEF_M_CNT,
  parameter int IW    = idx_width(M_CNT)
) (
  input  logic [M_CNT-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [M_CNT-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  // Walk the masters in rotated order starting after ptr; the first requester wins.
  // ptr <= M_CNT-1 and k <= M_CNT-1, so a single subtraction is enough to wrap.
  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < M_CNT; k++) begin
      cand = {{(32-IW){1'b0}}, ptr} + 32'(k) + 32'd1;
      if (cand >= 32'(M_CNT)) begin
        cand = cand - 32'(M_CNT);
      end
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/simple_arb.sv
// simple_arb -- M_CNT-master to single simple-bus slave arbiter.
//
// One transaction every three cycles: IDLE picks a winner and latches its
// request, ISSUE strobes s_re/s_we for one cycle, RESP pulses m_ack of the
// winner and captures read data.
//
// Configuration macro: SIMPLE_ARB_RR_EN
//   defined   -> round-robin; pointer register remembers the last winner
//   undefined -> fixed priority, lowest requesting index wins; no pointer flop
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   m_addr  in      M_CNT*AW  master i address at [i*AW +: AW]
//   m_re    in      M_CNT     read requests
//   m_we    in      M_CNT     write requests (a write wins over a read)
//   m_wd    in      M_CNT*DW  master i write data at [i*DW +: DW]
//   m_ack   out     M_CNT     one-cycle completion strobe
//   m_rd    out     DW        shared read data, valid with a reader's m_ack
//   s_addr  out     AW        slave address (holds last latched value)
//   s_re    out     1         slave read strobe
//   s_we    out     1         slave write strobe
//   s_wd    out     DW        slave write data (holds last latched value)
//   s_rd    in      DW        slave read data, valid the cycle after s_re
module simple_arb
  import simple_arb_pkg::*;
#(
  parameter int M_CNT = DEF_M_CNT,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [M_CNT*AW-1:0] m_addr,
  input  logic [M_CNT-1:0]    m_re,
  input  logic [M_CNT-1:0]    m_we,
  input  logic [M_CNT*DW-1:0] m_wd,
  output logic [M_CNT-1:0]    m_ack,
  output logic [DW-1:0]       m_rd,
  output logic [AW-1:0]       s_addr,
  output logic                s_re,
  output logic                s_we,
  output logic [DW-1:0]       s_wd,
  input  logic [DW-1:0]       s_rd
);

  localparam int IW = idx_width(M_CNT);

  arb_state_e       state_q, state_d;
  logic [M_CNT-1:0] gnt_q, gnt_d;
  logic             rd_q, rd_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wd_q, wd_d;
  logic             s_re_q, s_re_d;
  logic             s_we_q, s_we_d;
  logic [M_CNT-1:0] m_ack_q, m_ack_d;
  logic [DW-1:0]    m_rd_q, m_rd_d;

  logic [M_CNT-1:0] req;
  logic [M_CNT-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    ptr;

  assign req = m_re | m_we;

`ifdef SIMPLE_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // The pointer follows the winner so the search next time starts just after it.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick_any) begin
      ptr_d = pick_idx;
    end
  end

  assign ptr = ptr_q;
`else
  // A pointer stuck at the last index makes the picker start at master 0.
  assign ptr = IW'(M_CNT - 1);
`endif

  simple_arb_pick #(
    .M_CNT(M_CNT),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next-state and next-output logic. Strobes default low so they only ever
  // last one cycle; address/data/read-data registers hold unless reloaded.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    s_re_d  = 1'b0;
    s_we_d  = 1'b0;
    m_ack_d = '0;
    m_rd_d  = m_rd_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_grant;
          addr_d  = m_addr[pick_idx*AW +: AW];
          wd_d    = m_wd[pick_idx*DW +: DW];
          s_we_d  = m_we[pick_idx];
          s_re_d  = m_re[pick_idx] & ~m_we[pick_idx];
          rd_d    = m_re[pick_idx] & ~m_we[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        m_ack_d = gnt_q;
        state_d = RESP;
      end
      RESP: begin
        if (rd_q) begin
          m_rd_d = s_rd;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All arbiter state; reset aborts any transaction in flight without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      s_re_q  <= 1'b0;
      s_we_q  <= 1'b0;
      m_ack_q <= '0;
      m_rd_q  <= '0;
`ifdef SIMPLE_ARB_RR_EN
      ptr_q   <= IW'(M_CNT - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      s_re_q  <= s_re_d;
      s_we_q  <= s_we_d;
      m_ack_q <= m_ack_d;
      m_rd_q  <= m_rd_d;
`ifdef SIMPLE_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign m_ack  = m_ack_q;
  assign s_addr = addr_q;
  assign s_wd   = wd_q;
  assign s_re   = s_re_q;
  assign s_we   = s_we_q;

  // Slave data only arrives during RESP, the same cycle m_ack is high, so the
  // reader sees s_rd directly then; the register keeps it from then on.
  assign m_rd = (state_q == RESP && rd_q) ? s_rd : m_rd_q;

endmodule
